enm_fire_sched: RTL and testbench
=================================

Name: enm_fire_sched

Overview:
- Controller for the enemy-bullet datapath. Decides which enemy fires and when, and assigns each new shot to a free entry in a shared pool of bullet slots.
- Four enemy requesters are arbitrated round-robin. Each enemy has its own cooldown, and a global minimum gap applies between spawns.
- Sits between the enemy-position/alive logic and the bullet-motion datapath. The datapath reports slot releases (bullet hit the player or left the field); this block recycles those slots.

Parameters:
NUM_SLOT, 8, number of shared bullet slots (power of 2, 2..16)
SLOT_W, 3, width of a slot index (log2 NUM_SLOT)
COOLDOWN, 16, clk22 ticks an enemy waits after firing before it may fire again (1..31)
SPAWN_GAP, 2, idle ticks forced between consecutive spawns (0..7)

Ports:
clk22  in  1  game tick clock
rst  in  1  synchronous reset, active-high
fire_en  in  1  game running; 0 = no new grants, cooldowns frozen
enm_alive  in  4  bit i = enemy i present
slot_free  in  NUM_SLOT  bit j = datapath releases slot j this tick
spawn_valid  out  1  one-tick pulse: datapath loads slot spawn_slot from enemy spawn_enm position
spawn_enm  out  2  enemy index of the current spawn
spawn_slot  out  SLOT_W  slot index of the current spawn
slot_busy  out  NUM_SLOT  bit j = slot j allocated
busy_cnt  out  SLOT_W+1  population count of slot_busy (registered)

Behaviour:
- All state updates on posedge clk22. rst is checked first and overrides everything.
- Reset values:
  - spawn_valid=0, spawn_enm=0, spawn_slot=0, slot_busy=0, busy_cnt=0.
  - All cooldown[i]=COOLDOWN, gap_cnt=0, rr_ptr=3 (so enemy 0 has first priority), state=IDLE.
- Request: req[i] = fire_en & enm_alive[i] & (cooldown[i]==0).
- Cooldown per enemy, 5-bit:
  - enm_alive[i]=0: load COOLDOWN, so a newly alive enemy waits COOLDOWN ticks before its first shot.
  - Granted this tick: load COOLDOWN.
  - Else, fire_en=1 and cooldown>0: decrement.
  - Else: hold.
- FSM:
  - IDLE: grant when |req, slot_busy is not all ones, and gap_cnt==0.
    - Winner is the first requester in order rr_ptr+1, rr_ptr+2, rr_ptr+3, rr_ptr (mod 4).
    - Slot is the lowest-index bit with slot_busy==0.
    - On the grant edge: spawn_valid<=1, spawn_enm<=winner, spawn_slot<=slot, set slot_busy[slot], rr_ptr<=winner, gap_cnt<=SPAWN_GAP.
    - Next state is GAP if SPAWN_GAP>0, else IDLE.
  - GAP: decrement gap_cnt each tick; go to IDLE on the edge where gap_cnt goes 1->0. fire_en has no effect on the gap.
  - Minimum spacing between spawn_valid pulses is SPAWN_GAP+1 ticks; SPAWN_GAP=0 allows back-to-back pulses.
- spawn_valid is high for exactly one tick per grant and low on every non-grant tick. spawn_enm and spawn_slot hold their last values when spawn_valid is low.
- Latency: the grant uses registered state sampled at edge N; spawn_valid is visible after edge N. A slot_free bit sampled at edge N clears slot_busy after edge N, and that slot is first allocatable at edge N+1.
- Simultaneous events:
  - A release and an allocation on the same edge to different slots are both applied.
  - The allocator never picks a slot that was busy at the sample point, so the same slot cannot be released and allocated on one edge.
  - A slot_free bit for an already-free slot is ignored.
  - Multiple slot_free bits on one edge are all applied.
- Pool full (slot_busy all ones): no grant, rr_ptr unchanged, cooldowns of requesting enemies stay at 0 (the request stays pending). The first grant after a release goes to the highest-priority requester.
- fire_en=0:
  - No grant is issued. From IDLE the FSM stays IDLE; if in GAP, the gap still counts down.
  - Cooldowns freeze, except that an enemy not alive still reloads COOLDOWN.
  - Slot releases are still processed.
- An enemy that dies after its grant keeps its slot until the datapath releases it.
- busy_cnt is updated on the same edge as slot_busy and equals popcount of the new slot_busy.
- Reset asserted mid-GAP or mid-pulse returns everything to the reset values on that edge; spawn_valid=0 after it.

Test Plan:
- Reset, then enm_alive=4'b0001, fire_en=1, no releases, default parameters -> first spawn_valid 16 ticks after reset release (spawn_enm=0, spawn_slot=0); next pulse 17 ticks later with spawn_slot=1; busy_cnt increments 1, 2, ...
- enm_alive=4'b1111 with all cooldowns 0 at the same tick, SPAWN_GAP=2 -> grants to enemies 0, 1, 2, 3 at 3-tick spacing, slots 0, 1, 2, 3.
- Fill all 8 slots, hold requests, then pulse slot_free=8'b0010_0000 for one tick -> slot_busy[5] clears; the next spawn_valid uses spawn_slot=5 one tick later; busy_cnt goes 8->7->8.
- Grant to slot 2 on the same edge that slot_free[0] is pulsed with slots 0-1 busy -> slot_busy=8'b0000_0110 afterwards; no lost or duplicated slot.
- fire_en=0 for 10 ticks while enemy 1 has cooldown=5 -> no spawn_valid, cooldown stays 5. Drop enm_alive[1] -> cooldown reloads to 16.
- Assert rst on the tick after a grant while in GAP -> spawn_valid=0, slot_busy=0, busy_cnt=0, rr_ptr=3; the next grant goes to enemy 0.

Source files
------------

// File: rtl/enm_fire_sched_if.sv
// Handshake bundle between the enemy/bullet datapath and the fire scheduler.
// The scheduler takes the slave side. The datapath or a testbench takes the master side.
interface enm_fire_sched_if #(
    parameter int NUM_SLOT = 8,
    parameter int SLOT_W   = 3
);
    logic                fire_en;
    logic [3:0]          enm_alive;
    logic [NUM_SLOT-1:0] slot_free;
    logic                spawn_valid;
    logic [1:0]          spawn_enm;
    logic [SLOT_W-1:0]   spawn_slot;
    logic [NUM_SLOT-1:0] slot_busy;
    logic [SLOT_W:0]     busy_cnt;

    modport master (
        output fire_en, enm_alive, slot_free,
        input  spawn_valid, spawn_enm, spawn_slot, slot_busy, busy_cnt
    );

    modport slave (
        input  fire_en, enm_alive, slot_free,
        output spawn_valid, spawn_enm, spawn_slot, slot_busy, busy_cnt
    );
endinterface

// File: rtl/enm_fire_sched.sv
// Enemy fire scheduler: round-robin arbitration across four enemies, per-enemy cooldowns,
// a global spawn gap, and allocation of bullet slots from a shared recycled pool.
module enm_fire_sched #(
    parameter int NUM_SLOT  = 8,
    parameter int SLOT_W    = 3,
    parameter int COOLDOWN  = 16,
    parameter int SPAWN_GAP = 2
) (
    input  logic             clk22,
    input  logic             rst,
    enm_fire_sched_if.slave  bus
);
    typedef enum logic {IDLE, GAP} state_t;

    state_t              state_reg;
    logic [2:0]          gap_cnt_reg;
    logic [1:0]          rr_ptr_reg;
    logic                spawn_valid_reg;
    logic [1:0]          spawn_enm_reg;
    logic [SLOT_W-1:0]   spawn_slot_reg;
    logic [NUM_SLOT-1:0] slot_busy_reg;
    logic [SLOT_W:0]     busy_cnt_reg;

    logic [3:0]          req;
    logic [1:0]          winner;
    logic [SLOT_W-1:0]   free_slot;
    logic                grant;
    logic [NUM_SLOT-1:0] slot_busy_next;
    logic [SLOT_W:0]     busy_cnt_next;

    // First requester after rr_ptr, wrapping so rr_ptr itself is checked last.
    function automatic logic [1:0] pick_winner(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] w;
        logic       found;
        w     = '0;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (!found && r[p + 2'(k)]) begin
                w     = p + 2'(k);
                found = 1'b1;
            end
        end
        return w;
    endfunction

    function automatic logic [SLOT_W-1:0] lowest_free(input logic [NUM_SLOT-1:0] b);
        logic [SLOT_W-1:0] s;
        s = '0;
        for (int j = NUM_SLOT - 1; j >= 0; j--) begin
            if (!b[j]) s = SLOT_W'(j);
        end
        return s;
    endfunction

    assign winner    = pick_winner(req, rr_ptr_reg);
    assign free_slot = lowest_free(slot_busy_reg);
    assign grant     = (state_reg == IDLE) && (|req) && !(&slot_busy_reg) && (gap_cnt_reg == 3'd0);

    // The allocated slot was free at the sample point, so it never collides with a release.
    assign slot_busy_next = (slot_busy_reg & ~bus.slot_free)
                          | (grant ? (NUM_SLOT'(1) << free_slot) : '0);

    always_comb begin
        busy_cnt_next = '0;
        for (int j = 0; j < NUM_SLOT; j++) begin
            busy_cnt_next = busy_cnt_next + (SLOT_W + 1)'(slot_busy_next[j]);
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_enm
            logic [4:0] cooldown_reg;

            assign req[gi] = bus.fire_en & bus.enm_alive[gi] & (cooldown_reg == 5'd0);

            always_ff @(posedge clk22) begin
                if (rst) begin
                    cooldown_reg <= 5'(COOLDOWN);
                end else if (!bus.enm_alive[gi] || (grant && winner == 2'(gi))) begin
                    cooldown_reg <= 5'(COOLDOWN);
                end else if (bus.fire_en && cooldown_reg != 5'd0) begin
                    cooldown_reg <= cooldown_reg - 5'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk22) begin
        if (rst) begin
            state_reg       <= IDLE;
            gap_cnt_reg     <= 3'd0;
            rr_ptr_reg      <= 2'd3;
            spawn_valid_reg <= 1'b0;
            spawn_enm_reg   <= 2'd0;
            spawn_slot_reg  <= '0;
            slot_busy_reg   <= '0;
            busy_cnt_reg    <= '0;
        end else begin
            spawn_valid_reg <= grant;
            slot_busy_reg   <= slot_busy_next;
            busy_cnt_reg    <= busy_cnt_next;
            if (grant) begin
                spawn_enm_reg  <= winner;
                spawn_slot_reg <= free_slot;
                rr_ptr_reg     <= winner;
                gap_cnt_reg    <= 3'(SPAWN_GAP);
                state_reg      <= (SPAWN_GAP > 0) ? GAP : IDLE;
            end else if (state_reg == GAP) begin
                gap_cnt_reg <= gap_cnt_reg - 3'd1;
                if (gap_cnt_reg == 3'd1) state_reg <= IDLE;
            end
        end
    end

    assign bus.spawn_valid = spawn_valid_reg;
    assign bus.spawn_enm   = spawn_enm_reg;
    assign bus.spawn_slot  = spawn_slot_reg;
    assign bus.slot_busy   = slot_busy_reg;
    assign bus.busy_cnt    = busy_cnt_reg;
endmodule

// File: tb/tb_enm_fire_sched.sv
// Randomised scoreboard bench for enm_fire_sched against a cycle-level behavioural model
// that is kept as plain counters and a slot array.
module tb_enm_fire_sched;
    localparam int NS    = 8;
    localparam int SW    = 3;
    localparam int COOL  = 16;
    localparam int GAPT  = 2;

    logic clk22 = 1'b0;
    logic rst   = 1'b1;
    always #5 clk22 = ~clk22;

    enm_fire_sched_if #(.NUM_SLOT(NS), .SLOT_W(SW)) bus();

    enm_fire_sched #(
        .NUM_SLOT(NS), .SLOT_W(SW), .COOLDOWN(COOL), .SPAWN_GAP(GAPT)
    ) dut (
        .clk22 (clk22),
        .rst   (rst),
        .bus   (bus.slave)
    );

    typedef struct {int tag; int enm; int slot;} spawn_t;
    typedef struct {int valid; int enm; int slot; int busy; int cnt;} exp_t;

    spawn_t spawn_q[$];
    exp_t   exp_q[$];
    int     n_chk    = 0;
    int     n_fail   = 0;
    int     edge_cnt = 0;

    // Reference state: cooldowns, remaining gap ticks, last winner, the slot pool.
    int m_cd[4];
    int m_gap;
    int m_ptr;
    bit m_busy[NS];
    int m_enm;
    int m_slot;

    always @(posedge clk22) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, expv, edge_cnt);
        end
    endtask

    // Predicts the effect of the next rising edge from the inputs now being driven.
    task automatic model_step();
        exp_t   e;
        spawn_t s;
        int     w;
        int     sl;
        bit     full;
        int     nbusy;
        w = -1;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_cd[i] = COOL;
            for (int j = 0; j < NS; j++) m_busy[j] = 1'b0;
            m_gap = 0; m_ptr = 3; m_enm = 0; m_slot = 0;
        end else begin
            full = 1'b1;
            for (int j = 0; j < NS; j++) if (!m_busy[j]) full = 1'b0;
            if (m_gap == 0 && bus.fire_en && !full) begin
                for (int k = 1; k <= 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (w < 0 && bus.enm_alive[i] && m_cd[i] == 0) w = i;
                end
            end
            sl = -1;
            for (int j = 0; j < NS; j++) if (sl < 0 && !m_busy[j]) sl = j;
            for (int j = 0; j < NS; j++) if (bus.slot_free[j]) m_busy[j] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                if (!bus.enm_alive[i] || i == w) m_cd[i] = COOL;
                else if (bus.fire_en && m_cd[i] > 0) m_cd[i] = m_cd[i] - 1;
            end
            if (w >= 0) begin
                m_busy[sl] = 1'b1;
                m_enm  = w;
                m_slot = sl;
                m_ptr  = w;
                m_gap  = GAPT;
                s.tag = edge_cnt + 1; s.enm = w; s.slot = sl;
                spawn_q.push_back(s);
            end else if (m_gap > 0) begin
                m_gap = m_gap - 1;
            end
        end
        e.busy = 0;
        nbusy  = 0;
        for (int j = 0; j < NS; j++) begin
            e.busy = e.busy | (int'(m_busy[j]) << j);
            nbusy  = nbusy + int'(m_busy[j]);
        end
        e.cnt   = nbusy;
        e.valid = (w >= 0) ? 1 : 0;
        e.enm   = m_enm;
        e.slot  = m_slot;
        exp_q.push_back(e);
    endtask

    task automatic drive(input bit r, input bit fe, input logic [3:0] al, input logic [NS-1:0] fr);
        rst           = r;
        bus.fire_en   = fe;
        bus.enm_alive = al;
        bus.slot_free = fr;
        model_step();
        @(posedge clk22);
        #1;
    endtask

    // Monitor: per-edge state check, plus a spawn pop whenever the DUT pulses spawn_valid.
    initial begin
        exp_t   e;
        spawn_t s;
        forever begin
            @(negedge clk22);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("spawn_valid", int'(bus.spawn_valid), e.valid);
                chk("spawn_enm_hold", int'(bus.spawn_enm), e.enm);
                chk("spawn_slot_hold", int'(bus.spawn_slot), e.slot);
                chk("slot_busy", int'(bus.slot_busy), e.busy);
                chk("busy_cnt", int'(bus.busy_cnt), e.cnt);
            end
            if (bus.spawn_valid === 1'b1) begin
                if (spawn_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_spawn: got enm %0d slot %0d expected none at edge %0d",
                             bus.spawn_enm, bus.spawn_slot, edge_cnt);
                end else begin
                    s = spawn_q.pop_front();
                    chk("spawn_time", edge_cnt, s.tag);
                    chk("spawn_enm", int'(bus.spawn_enm), s.enm);
                    chk("spawn_slot", int'(bus.spawn_slot), s.slot);
                end
            end
        end
    end

    initial begin
        logic [3:0]    al;
        logic [NS-1:0] fr;
        bit            fe;

        // Single enemy from reset: first shot after the full cooldown.
        for (int c = 0; c < 3; c++) drive(1, 1, 4'b0001, '0);
        for (int c = 0; c < 60; c++) drive(0, 1, 4'b0001, '0);

        // All four enemies ready together, pool fills, then a single release of slot 5.
        for (int c = 0; c < 2; c++) drive(1, 1, 4'b1111, '0);
        for (int c = 0; c < 90; c++) drive(0, 1, 4'b1111, '0);
        drive(0, 1, 4'b1111, 8'b0010_0000);
        for (int c = 0; c < 6; c++) drive(0, 1, 4'b1111, '0);
        drive(0, 1, 4'b1111, 8'b0000_0011);
        for (int c = 0; c < 20; c++) drive(0, 1, 4'b1111, '0);

        // Frozen game with enemy 1 mid-cooldown, then enemy 1 dies and comes back.
        for (int c = 0; c < 2; c++) drive(1, 1, 4'b0010, '0);
        for (int c = 0; c < 11; c++) drive(0, 1, 4'b0010, '0);
        for (int c = 0; c < 10; c++) drive(0, 0, 4'b0010, '0);
        for (int c = 0; c < 8; c++) drive(0, 1, 4'b0010, '0);
        drive(0, 1, 4'b0000, '0);
        for (int c = 0; c < 20; c++) drive(0, 1, 4'b0010, '0);

        // Reset landing on or just after a grant, inside the gap.
        for (int off = 16; off <= 20; off++) begin
            for (int c = 0; c < 2; c++) drive(1, 1, 4'b1111, '0);
            for (int c = 0; c < off; c++) drive(0, 1, 4'b1111, '0);
        end
        for (int c = 0; c < 2; c++) drive(1, 1, 4'b1111, '0);
        for (int c = 0; c < 25; c++) drive(0, 1, 4'b1111, '0);

        // Random traffic: releases (including stray bits), fire_en stalls, deaths, resets.
        al = 4'b1111;
        fe = 1'b1;
        for (int c = 0; c < 2500; c++) begin
            if ($urandom_range(0, 39) == 0) al = 4'($urandom);
            if ($urandom_range(0, 19) == 0) fe = ~fe;
            fr = ($urandom_range(0, 2) == 0) ? (NS'($urandom) & NS'($urandom)) : '0;
            drive($urandom_range(0, 399) == 0, fe, al, fr);
        end

        for (int c = 0; c < 4; c++) drive(0, 0, 4'b0000, '0);
        @(negedge clk22);
        @(negedge clk22);
        chk("pending_spawns", spawn_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
